ultrasonic_scheduler: RTL

Round-robin controller that shares one echo-measurement datapath among N ultrasonic sensors. It fires each sensor's trigger in turn, times the selected echo pulse, applies a timeout, and publishes a per-sensor width result and a per-sensor obstacle flag. A guard gap between pings prevents cross-talk. It sits between the sensor pins and the obstacle-avoidance logic.

---
 rtl/ultrasonic_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ultrasonic_scheduler.sv
// Round-robin ultrasonic ranging scheduler: one shared echo timer
// serves N sensors, publishing width, timeout and obstacle per sensor.
module ultrasonic_scheduler #(
  parameter int N_SENSORS    = 4,
  parameter int WIDTH        = 22,
  parameter int TRIG_CYCLES  = 500,
  parameter int ECHO_TIMEOUT = 1500000,
  parameter int GAP_CYCLES   = 3000000,
  parameter int THRESH       = 55000
) (
  input  logic                         fpgaclk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [N_SENSORS-1:0]         echo,
  output logic [N_SENSORS-1:0]         trigger,
  output logic [N_SENSORS-1:0]         obstacle,
  output logic                         result_valid,
  output logic [$clog2(N_SENSORS)-1:0] result_id,
  output logic [WIDTH-1:0]             result_width,
  output logic                         result_timeout,
  output logic                         busy
);
  localparam int IDW = $clog2(N_SENSORS);
  localparam logic [WIDTH-1:0] TRIG_LAST = WIDTH'(TRIG_CYCLES - 1);
  localparam logic [WIDTH-1:0] GAP_LAST  = WIDTH'(GAP_CYCLES - 1);
  localparam logic [WIDTH-1:0] TO_LAST   = WIDTH'(ECHO_TIMEOUT - 1);
  localparam logic [WIDTH-1:0] TO_VAL    = WIDTH'(ECHO_TIMEOUT);
  localparam logic [WIDTH:0]   THR       = (WIDTH+1)'(THRESH);
  localparam logic [IDW-1:0]   CH_LAST   = IDW'(N_SENSORS - 1);

  if ((ECHO_TIMEOUT >> WIDTH) != 0 || (GAP_CYCLES >> WIDTH) != 0 ||
      (TRIG_CYCLES >> WIDTH) != 0 || ECHO_TIMEOUT < 2 ||
      TRIG_CYCLES < 1 || GAP_CYCLES < 1 ||
      N_SENSORS < 2 || N_SENSORS > 16) begin : g_bad_cfg
    $error("ultrasonic_scheduler: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       ch_q, ch_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [N_SENSORS-1:0] sync1_q, sync2_q, prev_q;
  logic [N_SENSORS-1:0] trigger_q, trigger_d;
  logic [N_SENSORS-1:0] obstacle_q, obstacle_d;
  logic                 valid_q, valid_d;
  logic                 to_q, to_d;
  logic                 busy_q, busy_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [WIDTH-1:0]     width_q, width_d;
  logic                 echo_lvl, echo_rise;
  logic                 done, done_to;
  logic [WIDTH-1:0]     done_w;

  // Only the selected channel is observed; prev_q makes a level
  // already high on WAIT entry invisible until it falls and rises.
  assign echo_lvl  = sync2_q[ch_q];
  assign echo_rise = sync2_q[ch_q] & ~prev_q[ch_q];

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    obstacle_d = obstacle_q;
    id_d       = id_q;
    width_d    = width_q;
    to_d       = to_q;
    valid_d    = 1'b0;
    done       = 1'b0;
    done_to    = 1'b0;
    done_w     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_TRIG;
          cnt_d   = '0;
        end
      end
      S_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (echo_rise) begin
          state_d = S_MEAS;
          cnt_d   = WIDTH'(1);
        end else if (cnt_q >= TO_LAST) begin
          done    = 1'b1;
          done_to = 1'b1;
          done_w  = TO_VAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MEAS: begin
        if (!echo_lvl) begin
          done   = 1'b1;
          done_w = cnt_q;
        end else if (cnt_q >= TO_LAST) begin
          done    = 1'b1;
          done_to = 1'b1;
          done_w  = TO_VAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
          state_d = enable ? S_TRIG : S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (done) begin
      state_d          = S_GAP;
      cnt_d            = '0;
      valid_d          = 1'b1;
      id_d             = ch_q;
      width_d          = done_w;
      to_d             = done_to;
      obstacle_d[ch_q] = !done_to && ({1'b0, done_w} < THR);
    end
    trigger_d = (state_d == S_TRIG) ? (N_SENSORS'(1) << ch_d) : '0;
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge fpgaclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      cnt_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      trigger_q  <= '0;
      obstacle_q <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      width_q    <= '0;
      to_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      sync1_q    <= echo;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      trigger_q  <= trigger_d;
      obstacle_q <= obstacle_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      width_q    <= width_d;
      to_q       <= to_d;
      busy_q     <= busy_d;
    end
  end

  assign trigger        = trigger_q;
  assign obstacle       = obstacle_q;
  assign result_valid   = valid_q;
  assign result_id      = id_q;
  assign result_width   = width_q;
  assign result_timeout = to_q;
  assign busy           = busy_q;
endmodule
